// File: rtl/pe_rr_encoder.sv
// pe_rr_encoder: registered priority encoder with a single-entry valid/ready output stage.
// Define PE_ROUND_ROBIN_EN for rotating priority; otherwise the highest-numbered set bit wins.
module pe_rr_encoder #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_req,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [$clog2(WIDTH)-1:0] out_idx,
    output logic                     out_any,
    input  logic                     out_ready
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] win_s;
    logic             any_r;
    logic             accept_s;
    logic             req_any_s;

    assign in_ready  = (state_r == EMPTY) || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign req_any_s = |in_req;

`ifdef PE_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_r;

    // Walk ptr, ptr-1, ..., 0, WIDTH-1, ..., ptr+1; the earliest set bit in that order wins.
    function automatic logic [IDX_W-1:0] encode_rr(input logic [WIDTH-1:0] req,
                                                   input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pos;
        int               p;
        idx = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            p   = (int'(ptr) >= k) ? (int'(ptr) - k) : (int'(ptr) + WIDTH - k);
            pos = IDX_W'(p);
            idx = req[pos] ? pos : idx;
        end
        return idx;
    endfunction

    assign win_s = encode_rr(in_req, ptr_r);

    // Pointer parks just below the last winner so that requester drops to lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= IDX_W'(WIDTH - 1);
        end else if (accept_s && req_any_s) begin
            ptr_r <= (win_s == '0) ? IDX_W'(WIDTH - 1) : (win_s - IDX_W'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Highest-numbered set bit wins; an all-zero vector encodes to 0.
    function automatic logic [IDX_W-1:0] encode_fixed(input logic [WIDTH-1:0] req);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = req[i] ? IDX_W'(i) : idx;
        end
        return idx;
    endfunction

    assign win_s = encode_fixed(in_req);
`endif

    // Next-state: accept always fills; release without accept empties.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (accept_s) begin
                    state_nxt_s = FULL;
                end else if (out_ready) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State and result register; the result is only overwritten on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
            idx_r   <= '0;
            any_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                idx_r <= win_s;
                any_r <= req_any_s;
            end else begin
                idx_r <= idx_r;
                any_r <= any_r;
            end
        end
    end

    assign out_valid = (state_r == FULL);
    assign out_idx   = idx_r;
    assign out_any   = any_r;
endmodule

// File: tb/tb_pe_rr_encoder.sv
// tb_pe_rr_encoder: directed and random checks of pe_rr_encoder against a behavioural model.
// Honours PE_ROUND_ROBIN_EN the same way as the design.
module tb_pe_rr_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_req = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_any;

    logic         v2 = 1'b0, v5 = 1'b0, v256 = 1'b0;
    logic [1:0]   r2 = 2'b00;
    logic [4:0]   r5 = 5'b00000;
    logic [255:0] r256 = '0;
    logic         ir2, ir5, ir256;
    logic         ov2, ov5, ov256;
    logic [0:0]   oi2;
    logic [2:0]   oi5;
    logic [7:0]   oi256;
    logic         oa2, oa5, oa256;

    int total = 0;
    int bad = 0;
    logic chk_on = 1'b0;

    // behavioural model state
    logic m_valid;
    int   m_idx;
    logic m_any;
    int   m_ptr;
    int   m_win;

    always #5 clk = ~clk;

    pe_rr_encoder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_req(in_req), .in_ready(in_ready),
        .out_valid(out_valid), .out_idx(out_idx), .out_any(out_any), .out_ready(out_ready)
    );

    pe_rr_encoder #(.WIDTH(2)) dut_w2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_req(r2), .in_ready(ir2),
        .out_valid(ov2), .out_idx(oi2), .out_any(oa2), .out_ready(1'b1)
    );

    pe_rr_encoder #(.WIDTH(5)) dut_w5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_req(r5), .in_ready(ir5),
        .out_valid(ov5), .out_idx(oi5), .out_any(oa5), .out_ready(1'b1)
    );

    pe_rr_encoder #(.WIDTH(256)) dut_w256 (
        .clk(clk), .rst(rst), .in_valid(v256), .in_req(r256), .in_ready(ir256),
        .out_valid(ov256), .out_idx(oi256), .out_any(oa256), .out_ready(1'b1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Winner from the priority rules: scan the search order, first set bit wins.
    function automatic int model_winner(input logic [7:0] req, input int ptr);
`ifdef PE_ROUND_ROBIN_EN
        for (int s = 0; s < 8; s++) begin
            int p;
            p = (ptr - s + 8) % 8;
            if (req[p]) return p;
        end
        return 0;
`else
        for (int b = 7; b >= 0; b--) begin
            if (req[b] && ptr >= 0) return b;
        end
        return 0;
`endif
    endfunction

    always_comb m_win = model_winner(in_req, m_ptr);

    // model: one-entry buffer fed by accepts, drained by out_ready
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_any   <= 1'b0;
            m_ptr   <= 7;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m_idx   <= m_win;
            m_any   <= (in_req != 8'h00);
            if (in_req != 8'h00) m_ptr <= (m_win == 0) ? 7 : m_win - 1;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_valid", int'(out_valid), int'(m_valid));
            chk("model_idx", int'(out_idx), m_idx);
            chk("model_any", int'(out_any), int'(m_any));
            chk("model_in_ready", int'(in_ready), int'(!m_valid || out_ready));
        end
    end

    // Called at negedge+1; applies inputs for the coming edge and returns at the next negedge+1.
    task automatic drive(input logic v, input logic [7:0] r, input logic ordy);
        in_valid  = v;
        in_req    = r;
        out_ready = ordy;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int exp_stream[4];
        logic [7:0] rq;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_idx", int'(out_idx), 0);
        chk("reset_any", int'(out_any), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        chk_on = 1'b1;

        // zero vector, then 0x81 still gives 7 (pointer untouched by zero)
        drive(1'b1, 8'h00, 1'b1);
        chk("zero_valid", int'(out_valid), 1);
        chk("zero_idx", int'(out_idx), 0);
        chk("zero_any", int'(out_any), 0);
        drive(1'b1, 8'h81, 1'b1);
        chk("after_zero_idx", int'(out_idx), 7);

        drive(1'b1, 8'b0010_1100, 1'b1);
        chk("fixed_valid", int'(out_valid), 1);
        chk("fixed_idx", int'(out_idx), 5);
        chk("fixed_any", int'(out_any), 1);

        // backpressure
        drive(1'b1, 8'h10, 1'b1);
        chk("bp_first_idx", int'(out_idx), 4);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 8'h02, 1'b0);
            chk("bp_hold_idx", int'(out_idx), 4);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b1;
        in_req    = 8'h02;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", int'(in_ready), 1);
        @(negedge clk);
        #1;
        chk("bp_next_idx", int'(out_idx), 1);
        chk("bp_next_valid", int'(out_valid), 1);

        // streaming from a fresh reset
        do_reset();
`ifdef PE_ROUND_ROBIN_EN
        exp_stream = '{7, 0, 7, 0};
`else
        exp_stream = '{7, 7, 7, 7};
`endif
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 8'b1000_0001, 1'b1);
            chk("stream_idx", int'(out_idx), exp_stream[s]);
            chk("stream_valid", int'(out_valid), 1);
        end

        // asynchronous reset while FULL
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("async_pre_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_in_ready", int'(in_ready), 1);
        chk("async_idx", int'(out_idx), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // width sweep
        v2 = 1'b1;  r2 = 2'b11;
        v5 = 1'b1;  r5 = 5'b10000;
        v256 = 1'b1; r256 = '0; r256[0] = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        chk("w2_valid", int'(ov2), 1);
        chk("w2_idx", int'(oi2), 1);
        chk("w5_idx", int'(oi5), 4);
        chk("w5_any", int'(oa5), 1);
        chk("w256_idx", int'(oi256), 0);
        chk("w256_any", int'(oa256), 1);
        r256 = '0; r256[200] = 1'b1; r256[3] = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        chk("w256_high_idx", int'(oi256), 200);
        v2 = 1'b0; v5 = 1'b0; v256 = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: rq = 8'h00;
                1: rq = 8'h01 << $urandom_range(0, 7);
                default: rq = 8'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, rq, $urandom_range(0, 2) != 0);
            if (i == 1500) begin
                #2 rst = 1'b1;
                #1;
                chk("rand_async_valid", int'(out_valid), 0);
                @(negedge clk);
                #1;
                rst = 1'b0;
            end
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pe_rr_encoder.md
# pe_rr_encoder

Parametrised, registered priority encoder with a valid/ready handshake on both sides and an optional round-robin priority mode. It takes a WIDTH-bit request vector and returns the index of the winning bit plus a nonzero flag, one cycle later, through a single-entry output register. It is the next generation of the 4-to-2 combinational priority encoders. It sits between request-collecting logic and a downstream consumer that may apply backpressure.

## Interface
- WIDTH, default 8: request vector width; legal range 2..256.
- IDX_W, derived localparam = $clog2(WIDTH): output index width; not overridable.

- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request vector present.
- in_req  input  WIDTH  request vector; bit i set means requester i is active.
- in_ready  output  1  block can accept a vector this cycle.
- out_valid  output  1  output register holds a result.
- out_idx  output  IDX_W  index of the winning request bit.
- out_any  output  1  high when the accepted in_req was nonzero.
- out_ready  input  1  consumer takes the result this cycle.

## Operation
- Two states, held in out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- in_ready = !out_valid || out_ready. This is combinational, with no other dependency.
- Accept occurs when in_valid && in_ready. The encoded result is loaded into the output register, and the state becomes FULL.
- Release occurs when out_valid && out_ready with no accept in the same cycle. The state becomes EMPTY. out_idx and out_any hold their last values.
- Simultaneous release and accept while FULL: the register is overwritten with the new result, the state stays FULL, and no bubble is inserted.
- Accept while EMPTY with out_ready high: the new result is loaded; out_ready has no effect because out_valid was 0.
- Fixed priority (default): the highest-numbered set bit wins, so the MSB has the highest priority.
- All-zero in_req: out_idx=0, out_any=0, and the result is still delivered with out_valid=1.
- While FULL and out_ready=0:
  - in_req is ignored.
  - The output register is stable.
  - No internal state changes.
- The round-robin pointer (see Configuration) updates only on an accept with a nonzero in_req.

## Timing
- Reset values:
  - out_valid=0, out_idx=0, out_any=0.
  - in_ready=1, since it is derived from out_valid.
  - Round-robin pointer = WIDTH-1.
- Latency: a result appears on the rising edge after the accept, 1 cycle.
- Throughput: 1 vector per cycle while out_ready is held high.
- Reset asserted mid-operation: a pending result is discarded immediately (asynchronous), and all state returns to the reset values. The first accept after rst deasserts behaves as after power-up.
- out_idx and out_any are registered outputs. in_ready is the only combinational output.

## Configuration
- Macro: PE_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority using pointer ptr.
  - Search order: ptr, ptr-1, …, 0, WIDTH-1, …, ptr+1. The first set bit wins.
  - After a nonzero accept with winner g: ptr ← (g==0) ? WIDTH-1 : g-1.
  - Zero vectors leave ptr unchanged.
  - The first grant after reset equals fixed priority.
- Undefined:
  - Fixed MSB-first priority.
  - No pointer register is synthesised.
  - The handshake and latency are identical to the defined case.

## Test plan
- Reset check, WIDTH=8: assert rst with clk running. Required: out_valid=0, out_idx=0, out_any=0, in_ready=1. Assert rst asynchronously while FULL; out_valid must drop before the next clk edge.
- Fixed encode: in_req=8'b0010_1100 accepted with out_ready=1. Next cycle: out_valid=1, out_idx=5, out_any=1.
- Zero request: in_req=8'h00 accepted. Next cycle: out_valid=1, out_idx=0, out_any=0. Under PE_ROUND_ROBIN_EN, a following 8'b1000_0001 still yields idx 7.
- Backpressure:
  - Accept 8'h10, then hold out_ready=0 for 3 cycles while presenting 8'h02. Required: out_idx=4 stable and in_ready=0.
  - Raise out_ready. Required: 8'h02 is accepted the same cycle, and out_idx=1 on the next cycle with no EMPTY cycle between.
- Streaming: 8'b1000_0001 presented on 4 consecutive accepts with out_ready=1.
  - Without macro: out_idx sequence 7,7,7,7.
  - With PE_ROUND_ROBIN_EN: 7,0,7,0.
- Width sweep:
  - WIDTH=2: in_req=2'b11 gives idx 1.
  - WIDTH=5: in_req=5'b10000 gives idx 4 and IDX_W=3.
  - WIDTH=256: only bit 0 set gives idx 0 and out_any=1.
